// File: rtl/cap_arb_pkg.sv
// Shared types and default widths for the capture-register arbiter.
package cap_arb_pkg;

   typedef enum logic {
      SRC_A = 1'b0,
      SRC_B = 1'b1
   } src_e;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   localparam int unsigned CAP_A_W = 8;
   localparam int unsigned CAP_B_W = 7;
   localparam int unsigned CAP_Q_W = 6;

endpackage

// File: rtl/cap_arb_mux_reg_rr.sv
// Two-way round-robin grant logic; the caller owns the last-winner register.
module cap_arb_rr (
   input  logic en,
   input  logic req_a,
   input  logic req_b,
   input  logic last_b,
   output logic gnt_a,
   output logic gnt_b
);

   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      if (en) begin
         if (req_a && req_b) begin
            // Contention goes to whichever source did not win last time.
            gnt_a = last_b;
            gnt_b = !last_b;
         end else begin
            gnt_a = req_a;
            gnt_b = req_b;
         end
      end
   end

endmodule

// File: rtl/cap_arb_mux_reg.sv
// Round-robin shared capture register with valid/ready output.
// Optional q_trunc output enabled by defining CAP_ARB_TRUNC_FLAG_EN.
module cap_arb_mux_reg
   import cap_arb_pkg::*;
#(
   parameter int unsigned A_WIDTH = CAP_A_W,
   parameter int unsigned B_WIDTH = CAP_B_W,
   parameter int unsigned Q_WIDTH = CAP_Q_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_a,
   input  logic [A_WIDTH-1:0] data_a,
   output logic               gnt_a,
   input  logic               req_b,
   input  logic [B_WIDTH-1:0] data_b,
   output logic               gnt_b,
   output logic [Q_WIDTH-1:0] q,
   output logic               q_src,
   output logic               q_valid,
   input  logic               q_ready
`ifdef CAP_ARB_TRUNC_FLAG_EN
   ,
   output logic               q_trunc
`endif
);

   state_e             state_q, state_d;
   src_e               src_q;
   logic [Q_WIDTH-1:0] q_q;
   logic [Q_WIDTH-1:0] cap_d;
   logic               last_b_q;
   logic               can_load;
   logic               grant;

   // Grants are suppressed during reset so nothing is captured that cycle.
   assign can_load = !rst && ((state_q == EMPTY) || q_ready);

   cap_arb_rr u_rr (
      .en     (can_load),
      .req_a  (req_a),
      .req_b  (req_b),
      .last_b (last_b_q),
      .gnt_a  (gnt_a),
      .gnt_b  (gnt_b)
   );

   assign grant = gnt_a | gnt_b;
   assign cap_d = gnt_b ? Q_WIDTH'(data_b) : Q_WIDTH'(data_a);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         EMPTY: if (grant) state_d = FULL;
         FULL:  if (q_ready && !grant) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= EMPTY;
         q_q      <= '0;
         src_q    <= SRC_A;
         last_b_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            q_q      <= cap_d;
            src_q    <= gnt_b ? SRC_B : SRC_A;
            last_b_q <= gnt_b;
         end
      end
   end

`ifdef CAP_ARB_TRUNC_FLAG_EN
   logic trunc_d;
   logic trunc_q;

   // Shifting out the kept bits leaves only the discarded ones.
   assign trunc_d = gnt_b ? |(data_b >> Q_WIDTH) : |(data_a >> Q_WIDTH);

   always_ff @(posedge clk) begin
      if (rst) begin
         trunc_q <= 1'b0;
      end else if (grant) begin
         trunc_q <= trunc_d;
      end
   end

   assign q_trunc = trunc_q;
`endif

   assign q       = q_q;
   assign q_src   = src_q;
   assign q_valid = (state_q == FULL);

endmodule

// File: tb/tb_cap_arb_mux_reg.sv
// Directed vector table plus randomized traffic against a behavioural model.
module tb_cap_arb_mux_reg;

   localparam int unsigned AW = 8;
   localparam int unsigned BW = 7;
   localparam int unsigned QW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_a, req_b, q_ready;
   logic [AW-1:0] data_a;
   logic [BW-1:0] data_b;
   logic          gnt_a, gnt_b, q_src, q_valid;
   logic [QW-1:0] q;
`ifdef CAP_ARB_TRUNC_FLAG_EN
   logic          q_trunc;
`endif

   always #5 clk = ~clk;

   cap_arb_mux_reg #(
      .A_WIDTH (AW),
      .B_WIDTH (BW),
      .Q_WIDTH (QW)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req_a   (req_a),
      .data_a  (data_a),
      .gnt_a   (gnt_a),
      .req_b   (req_b),
      .data_b  (data_b),
      .gnt_b   (gnt_b),
      .q       (q),
      .q_src   (q_src),
      .q_valid (q_valid),
      .q_ready (q_ready)
`ifdef CAP_ARB_TRUNC_FLAG_EN
      ,
      .q_trunc (q_trunc)
`endif
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Behavioural model: what the consumer should see, by the arbitration rules.
   int m_q;
   bit m_src, m_valid, m_last, m_trunc;

   typedef struct {
      bit       rst;
      bit       ra;
      bit [7:0] da;
      bit       rb;
      bit [6:0] db;
      bit       rdy;
      bit       ega;
      bit       egb;
      bit [5:0] eq;
      bit       esrc;
      bit       ev;
   } vec_t;

   vec_t vecs[19];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_grant(output bit ga, output bit gb);
      bit can;
      ga  = 1'b0;
      gb  = 1'b0;
      can = !rst && (!m_valid || q_ready);
      if (can) begin
         if (req_a && req_b) begin
            if (m_last) ga = 1'b1;
            else gb = 1'b1;
         end else begin
            ga = req_a;
            gb = req_b;
         end
      end
   endtask

   task automatic model_edge();
      bit ga, gb;
      model_grant(ga, gb);
      if (rst) begin
         m_q = 0; m_src = 0; m_valid = 0; m_last = 0; m_trunc = 0;
      end else if (ga) begin
         m_q = int'(data_a) % (1 << QW);
         m_src = 0; m_valid = 1; m_last = 0;
         m_trunc = (int'(data_a) >= (1 << QW));
      end else if (gb) begin
         m_q = int'(data_b) % (1 << QW);
         m_src = 1; m_valid = 1; m_last = 1;
         m_trunc = (int'(data_b) >= (1 << QW));
      end else if (m_valid && q_ready) begin
         m_valid = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   initial begin
      //            rst ra  da     rb  db     rdy gA gB  q      src v
      vecs[0]  = '{1, 1, 8'hAA, 0, 7'h00, 1, 0, 0, 6'h00, 0, 0};
      vecs[1]  = '{0, 1, 8'hAA, 0, 7'h00, 1, 1, 0, 6'h00, 0, 0};
      vecs[2]  = '{0, 0, 8'h00, 1, 7'h3B, 1, 0, 1, 6'h2A, 0, 1};
      vecs[3]  = '{0, 0, 8'h00, 0, 7'h00, 1, 0, 0, 6'h3B, 1, 1};
      vecs[4]  = '{0, 0, 8'h00, 0, 7'h00, 0, 0, 0, 6'h3B, 1, 0};
      vecs[5]  = '{1, 1, 8'h15, 1, 7'h2C, 1, 0, 0, 6'h3B, 1, 0};
      vecs[6]  = '{0, 1, 8'h15, 1, 7'h2C, 1, 0, 1, 6'h00, 0, 0};
      vecs[7]  = '{0, 1, 8'h15, 1, 7'h2C, 1, 1, 0, 6'h2C, 1, 1};
      vecs[8]  = '{0, 1, 8'h15, 1, 7'h2C, 1, 0, 1, 6'h15, 0, 1};
      vecs[9]  = '{0, 1, 8'h15, 1, 7'h2C, 1, 1, 0, 6'h2C, 1, 1};
      vecs[10] = '{0, 1, 8'hAA, 0, 7'h00, 0, 0, 0, 6'h15, 0, 1};
      vecs[11] = '{0, 1, 8'hAA, 0, 7'h00, 0, 0, 0, 6'h15, 0, 1};
      vecs[12] = '{0, 1, 8'hAA, 0, 7'h00, 0, 0, 0, 6'h15, 0, 1};
      vecs[13] = '{0, 1, 8'hAA, 0, 7'h00, 1, 1, 0, 6'h15, 0, 1};
      vecs[14] = '{1, 0, 8'h00, 1, 7'h7F, 0, 0, 0, 6'h2A, 0, 1};
      vecs[15] = '{0, 0, 8'h00, 1, 7'h7F, 0, 0, 1, 6'h00, 0, 0};
      vecs[16] = '{0, 0, 8'h00, 0, 7'h00, 0, 0, 0, 6'h3F, 1, 1};
      vecs[17] = '{0, 1, 8'h15, 1, 7'h01, 1, 1, 0, 6'h3F, 1, 1};
      vecs[18] = '{0, 0, 8'h00, 0, 7'h00, 1, 0, 0, 6'h15, 0, 1};

      rst = 1'b1; req_a = 1'b0; req_b = 1'b0; q_ready = 1'b0;
      data_a = '0; data_b = '0;
      m_q = 0; m_src = 0; m_valid = 0; m_last = 0; m_trunc = 0;
      tick();

      for (int i = 0; i < 19; i++) begin
         rst = vecs[i].rst; req_a = vecs[i].ra; data_a = vecs[i].da;
         req_b = vecs[i].rb; data_b = vecs[i].db; q_ready = vecs[i].rdy;
         #3;
         check($sformatf("vec%0d gnt_a", i), 32'(gnt_a), 32'(vecs[i].ega));
         check($sformatf("vec%0d gnt_b", i), 32'(gnt_b), 32'(vecs[i].egb));
         check($sformatf("vec%0d q", i), 32'(q), 32'(vecs[i].eq));
         check($sformatf("vec%0d q_src", i), 32'(q_src), 32'(vecs[i].esrc));
         check($sformatf("vec%0d q_valid", i), 32'(q_valid), 32'(vecs[i].ev));
         tick();
      end

      for (int i = 0; i < 400; i++) begin
         bit ga, gb;
         rst     = ($urandom_range(0, 29) == 0);
         req_a   = ($urandom_range(0, 3) != 0);
         req_b   = ($urandom_range(0, 3) != 0);
         data_a  = AW'($urandom);
         data_b  = BW'($urandom);
         q_ready = ($urandom_range(0, 2) != 0);
         #3;
         model_grant(ga, gb);
         check("rand gnt_a", 32'(gnt_a), 32'(ga));
         check("rand gnt_b", 32'(gnt_b), 32'(gb));
         check("rand q", 32'(q), 32'(m_q));
         check("rand q_src", 32'(q_src), 32'(m_src));
         check("rand q_valid", 32'(q_valid), 32'(m_valid));
`ifdef CAP_ARB_TRUNC_FLAG_EN
         check("rand q_trunc", 32'(q_trunc), 32'(m_trunc));
`endif
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
